// File: rtl/ir_pulse_capture_ctrl.sv
// IR pulse-width capture: times every high/low pulse on ir_in and queues the results for an Avalon-MM master.
// Optional glitch filter on the synchronized input is enabled by defining IR_GLITCH_FILTER_EN.
module ir_pulse_capture_ctrl #(
   parameter int unsigned CNT_WIDTH       = 16,
   parameter int unsigned FIFO_DEPTH      = 16,
   parameter int unsigned DEFAULT_TIMEOUT = 50000,
   parameter int unsigned GLITCH_CYCLES   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   input  logic        ir_in
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned EW = CNT_WIDTH + 2;

   typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;

   logic                 s1_reg, s2_reg, lvl, lvl_d_reg, edge_det;
   state_t               state_reg, state_next;
   logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
   logic [CNT_WIDTH-1:0] timeout_reg;
   logic                 enable_reg, irq_mask_reg, overrun_reg;
   logic                 push;
   logic [EW-1:0]        push_word;

   logic [EW-1:0]        mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0]        level_reg;
   logic                 fifo_empty, fifo_full, do_push, do_pop;
   logic [EW-1:0]        head;
   logic [31:0]          data_word, status_word;

   logic rd, wr, flush, pop_req;
   logic unused_ok;

   assign rd      = chipselect & ~read_n;
   assign wr      = chipselect & ~write_n;
   assign flush   = wr & (address == 2'd2) & writedata[2];
   assign pop_req = rd & (address == 2'd0);
   assign unused_ok = ^{writedata, 32'(GLITCH_CYCLES)};

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_reg    <= 1'b0;
         s2_reg    <= 1'b0;
         lvl_d_reg <= 1'b0;
      end else begin
         s1_reg    <= ir_in;
         s2_reg    <= s1_reg;
         lvl_d_reg <= lvl;
      end
   end

`ifdef IR_GLITCH_FILTER_EN
   localparam int unsigned GW = $clog2(GLITCH_CYCLES + 1);
   logic          filt_reg;
   logic [GW-1:0] filt_cnt_reg;

   // The filtered level only follows s2 once it has disagreed for GLITCH_CYCLES samples in a row.
   always_ff @(posedge clk) begin
      if (reset) begin
         filt_reg     <= 1'b0;
         filt_cnt_reg <= '0;
      end else if (s2_reg != filt_reg) begin
         if (filt_cnt_reg == GW'(GLITCH_CYCLES - 1)) begin
            filt_reg     <= s2_reg;
            filt_cnt_reg <= '0;
         end else begin
            filt_cnt_reg <= filt_cnt_reg + 1'b1;
         end
      end else begin
         filt_cnt_reg <= '0;
      end
   end

   assign lvl = filt_reg;
`else
   assign lvl = s2_reg;
`endif

   assign edge_det = lvl ^ lvl_d_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      push       = 1'b0;
      push_word  = '0;
      if (!enable_reg) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            IDLE: state_next = WAIT_EDGE;
            WAIT_EDGE: begin
               if (edge_det) begin
                  state_next = MEASURE;
                  cnt_next   = CNT_WIDTH'(1);
               end
            end
            MEASURE: begin
               // An edge landing exactly on the timeout count still ends the pulse normally.
               if (edge_det) begin
                  push      = 1'b1;
                  push_word = {lvl_d_reg, 1'b0, cnt_reg};
                  cnt_next  = CNT_WIDTH'(1);
               end else if ((timeout_reg != '0) && (cnt_reg == timeout_reg)) begin
                  push       = 1'b1;
                  push_word  = {lvl, 1'b1, cnt_reg};
                  state_next = WAIT_EDGE;
               end else if (cnt_reg != '1) begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign fifo_empty = (level_reg == '0);
   assign fifo_full  = (level_reg == LW'(FIFO_DEPTH));
   assign do_pop     = pop_req & ~fifo_empty & ~flush;
   assign do_push    = push & (~fifo_full | do_pop) & ~flush;
   assign head       = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_word;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         enable_reg   <= 1'b0;
         irq_mask_reg <= 1'b0;
         timeout_reg  <= CNT_WIDTH'(DEFAULT_TIMEOUT);
         overrun_reg  <= 1'b0;
      end else begin
         if (wr && (address == 2'd2)) begin
            enable_reg   <= writedata[0];
            irq_mask_reg <= writedata[1];
         end
         if (wr && (address == 2'd3)) begin
            timeout_reg <= writedata[CNT_WIDTH-1:0];
         end
         // A new overflow wins over a simultaneous clear so no lost entry goes unreported.
         if (push && fifo_full && !do_pop && !flush) begin
            overrun_reg <= 1'b1;
         end else if (wr && (address == 2'd1) && writedata[10]) begin
            overrun_reg <= 1'b0;
         end
      end
   end

   always_comb begin
      data_word   = '0;
      status_word = '0;
      if (!fifo_empty) begin
         data_word     = 32'(head[CNT_WIDTH-1:0]);
         data_word[31] = head[EW-1];
         data_word[30] = head[EW-2];
      end
      status_word[6:0] = 7'(level_reg);
      status_word[8]   = fifo_empty;
      status_word[9]   = fifo_full;
      status_word[10]  = overrun_reg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= '0;
      end else if (rd) begin
         case (address)
            2'd0:    readdata <= data_word;
            2'd1:    readdata <= status_word;
            2'd2:    readdata <= {30'd0, irq_mask_reg, enable_reg};
            2'd3:    readdata <= 32'(timeout_reg);
            default: readdata <= '0;
         endcase
      end else begin
         readdata <= '0;
      end
   end

   assign irq = irq_mask_reg & (~fifo_empty | overrun_reg);

endmodule

// File: tb/tb_ir_pulse_capture_ctrl.sv
// Randomized bench for ir_pulse_capture_ctrl against a pulse-list reference model (queue of expected FIFO words).
module tb_ir_pulse_capture_ctrl;

   localparam int DEPTH  = 16;
   localparam int GLITCH = 8;
`ifdef IR_GLITCH_FILTER_EN
   localparam int MIN_LEN  = GLITCH;
   localparam int FILT_DLY = GLITCH;
`else
   localparam int MIN_LEN  = 1;
   localparam int FILT_DLY = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        read_n = 1'b1;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        irq;
   logic        ir_in = 1'b0;

   ir_pulse_capture_ctrl #(
      .CNT_WIDTH(16), .FIFO_DEPTH(DEPTH), .DEFAULT_TIMEOUT(50000), .GLITCH_CYCLES(GLITCH)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read_n(read_n), .write_n(write_n), .writedata(writedata),
      .readdata(readdata), .irq(irq), .ir_in(ir_in)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: expected FIFO contents and capture bookkeeping
   logic [31:0] m_q[$];
   bit          m_over  = 1'b0;
   bit          m_armed = 1'b0;
   bit          m_en    = 1'b0;
   bit          m_mask  = 1'b0;
   int          m_T     = 50000;
   longint      m_last  = 0;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic model_push(input logic [31:0] w);
      if (m_q.size() == DEPTH) m_over = 1'b1;
      else m_q.push_back(w);
   endtask

   // A transition ends the pulse of level prev that began at m_last.
   task automatic model_edge(input longint t, input logic prev);
      longint L;
      L = t - m_last;
      if (m_en) begin
         if (m_armed) begin
            if (m_T != 0 && L > m_T) model_push({prev, 1'b1, 14'd0, 16'(m_T)});
            else model_push({prev, 1'b0, 14'd0, (L > 65535) ? 16'hFFFF : 16'(L)});
         end
         m_armed = 1'b1;
      end
      m_last = t;
   endtask

   task automatic ir_toggle();
      logic prev;
      prev  = ir_in;
      ir_in = ~ir_in;
      model_edge(cyc, prev);
   endtask

   task automatic settle();
      int hold;
      hold = (m_T == 0) ? 200 : m_T + 30 + FILT_DLY;
      wait_cycles(hold);
      if (m_en && m_armed && m_T != 0 && (cyc - m_last) > m_T) begin
         model_push({ir_in, 1'b1, 14'd0, 16'(m_T)});
         m_armed = 1'b0;
      end
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
      address = addr; writedata = data; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
      $display("[TB] wr addr=%0d data=0x%08h", addr, data);
      case (addr)
         2'd1: if (data[10]) m_over = 1'b0;
         2'd2: begin
            if (!data[0]) m_armed = 1'b0;
            m_en   = data[0];
            m_mask = data[1];
            if (data[2]) m_q.delete();
         end
         2'd3: m_T = int'(data[15:0]);
         default: ;
      endcase
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [31:0] d);
      address = addr; chipselect = 1'b1; read_n = 1'b0;
      tick();
      chipselect = 1'b0; read_n = 1'b1;
      d = readdata;
      $display("[TB] rd addr=%0d data=0x%08h", addr, d);
   endtask

   task automatic read_data(input string tag, output logic [31:0] d);
      logic [31:0] exp;
      exp = (m_q.size() != 0) ? m_q.pop_front() : 32'h0;
      bus_read(2'd0, d);
      check_value(tag, d, exp);
   endtask

   task automatic check_status(input string tag);
      logic [31:0] d, exp;
      int sz;
      sz  = m_q.size();
      exp = 32'(sz);
      exp[8]  = (sz == 0);
      exp[9]  = (sz == DEPTH);
      exp[10] = m_over;
      bus_read(2'd1, d);
      check_value(tag, d, exp);
   endtask

   task automatic check_irq(input string tag);
      check_value(tag, {31'd0, irq}, {31'd0, m_mask & ((m_q.size() != 0) | m_over)});
   endtask

   task automatic drain(input string tag);
      logic [31:0] d;
      int n;
      n = m_q.size();
      for (int i = 0; i < n; i++) read_data(tag, d);
      read_data({tag, "_empty"}, d);
      check_status({tag, "_status"});
   endtask

   task automatic run_pulses(input int n, input int lo, input int hi);
      for (int i = 0; i < n; i++) begin
         ir_toggle();
         wait_cycles($urandom_range(hi, lo));
      end
   endtask

   initial begin
      #2_000_000;
      n_fail++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      logic [31:0] d;
      logic        prev;
      longint      t0;

      wait_cycles(3);
      reset = 1'b0;
      tick();
      check_value("rst_readdata", readdata, 32'h0);
      check_value("rst_irq", {31'd0, irq}, 32'h0);
      check_status("rst_status");
      bus_read(2'd2, d);
      check_value("rst_control", d, 32'h0);
      bus_read(2'd3, d);
      check_value("rst_timeout", d, 32'd50000);

      // Single 560-cycle low pulse followed by a timeout on the high level
      ir_toggle();
      wait_cycles(10);
      bus_write(2'd3, 32'd1000);
      bus_write(2'd2, 32'h3);
      wait_cycles(5);
      ir_toggle();
      wait_cycles(560);
      ir_toggle();
      wait_cycles(5 + FILT_DLY);
      check_irq("irq_pending");
      read_data("pulse560", d);
      check_value("pulse560_lit", d, 32'h0000_0230);
      check_irq("irq_cleared");
      settle();
      check_status("timeout_status");
      read_data("timeout_entry", d);
      check_value("timeout_lit", d, 32'hC000_03E8);
      wait_cycles(2000);
      check_status("idle_no_push");

      // Pulse equal to the timeout is a normal entry; one longer times out
      bus_write(2'd3, 32'd100);
      ir_toggle();
      wait_cycles(100);
      ir_toggle();
      wait_cycles(101);
      ir_toggle();
      wait_cycles(50);
      ir_toggle();
      settle();
      check_status("boundary_status");
      drain("boundary");

      // Random bursts
      for (int b = 0; b < 8; b++) begin
         bus_write(2'd3, 32'($urandom_range(300, 30)));
         if (b == 3) bus_write(2'd2, 32'h1);
         if (b == 4) bus_write(2'd2, 32'h3);
         run_pulses($urandom_range(10, 1), MIN_LEN, 350);
         settle();
         check_irq("rand_irq");
         check_status("rand_status");
         drain("rand");
      end

      // TIMEOUT=0 never times out; the next edge reports the long pulse
      bus_write(2'd3, 32'd0);
      ir_toggle();
      wait_cycles(3000);
      check_status("t0_no_push");
      ir_toggle();
      wait_cycles(10 + FILT_DLY);
      bus_write(2'd3, 32'd200);
      settle();
      check_status("t0_status");
      drain("t0");

      // Overrun: 17 pulses into a 16-deep FIFO, then flush keeps overrun
      bus_write(2'd3, 32'd1000);
      bus_write(2'd2, 32'h7);
      run_pulses(18, 20, 60);
      settle();
      check_status("ovr_status");
      check_irq("ovr_irq");
      for (int i = 0; i < 3; i++) read_data("ovr_data", d);
      bus_write(2'd2, 32'h7);
      check_status("flush_keeps_ovr");
      check_irq("flush_irq");
      bus_write(2'd1, 32'h400);
      check_status("ovr_cleared");
      check_irq("ovr_cleared_irq");

      // Full FIFO: DATA read in the same cycle as a new push
      run_pulses(17, 20, 60);
      check_status("full_status");
      prev  = ir_in;
      ir_in = ~ir_in;
      t0    = cyc;
      wait_cycles(2 + FILT_DLY);
      read_data("coinc_pop", d);
      model_edge(t0, prev);
      wait_cycles(5);
      check_status("coinc_level");
      drain("coinc");
      settle();
      drain("coinc_tail");

      // Disable mid-measurement, toggle while disabled, then re-enable
      ir_toggle();
      wait_cycles(50);
      ir_toggle();
      wait_cycles(30);
      bus_write(2'd2, 32'h2);
      wait_cycles(20);
      ir_toggle();
      wait_cycles(20 + FILT_DLY);
      check_status("dis_no_push");
      bus_write(2'd2, 32'h3);
      wait_cycles(10);
      ir_toggle();
      wait_cycles(40 + FILT_DLY);
      check_status("reen_first_edge");
      wait_cycles(37 - FILT_DLY);
      ir_toggle();
      settle();
      check_status("reen_status");
      drain("reen");

`ifdef IR_GLITCH_FILTER_EN
      if (ir_in == 1'b0) begin
         ir_toggle();
         settle();
         drain("glitch_prep");
      end
      ir_in = 1'b0;
      wait_cycles(5);
      ir_in = 1'b1;
      wait_cycles(50);
      check_status("glitch_none");
      ir_toggle();
      wait_cycles(100);
      ir_toggle();
      wait_cycles(5 + FILT_DLY);
      read_data("glitch_pulse", d);
      check_value("glitch_dur", d, 32'h0000_0064);
      settle();
      drain("glitch");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ir_pulse_capture_ctrl.md
Name: ir_pulse_capture_ctrl

Overview:
- Avalon-MM slave controller that sequences capture of an IR receiver line.
- Measures the clock-cycle duration of every high and low pulse and queues {level, timeout, duration} words in an internal FIFO.
- Raises an interrupt so the Nios II CPU can decode remote-control frames without polling a bare PIO edge-capture bit.
- Sits between the IR receiver pin and the system interconnect.

Parameters:
- CNT_WIDTH, 16: duration counter width; range 8..30.
- FIFO_DEPTH, 16: FIFO entries; power of 2, range 2..64.
- DEFAULT_TIMEOUT, 16'd50000: reset value of the TIMEOUT register.
- GLITCH_CYCLES, 8: filter length; used only with IR_GLITCH_FILTER_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  word address: 0 DATA, 1 STATUS, 2 CONTROL, 3 TIMEOUT.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  interrupt, level, active-high.
- ir_in  in  1  asynchronous IR receiver output.

Behaviour:
- Reset (clk edge with reset=1):
  - readdata=0, irq=0, state=IDLE, FIFO empty, overrun=0, CONTROL=0, TIMEOUT=DEFAULT_TIMEOUT, cnt=0, sync flops=0.
- Input path:
  - ir_in passes through 2 sync flops s1->s2, giving level lvl=s2 and previous level lvl_d.
  - edge = lvl ^ lvl_d.
- Reads:
  - readdata is registered and updated every clk; 1-cycle latency.
  - rd = chipselect & ~read_n. wr = chipselect & ~write_n.
- DATA (addr 0):
  - Returns FIFO head: [31]=level of ended pulse, [30]=timeout flag, [29:CNT_WIDTH]=0, [CNT_WIDTH-1:0]=duration.
  - A read pops the entry when the FIFO is not empty.
  - Reading when empty returns 0 and does not pop.
  - Writes are ignored.
- STATUS (addr 1):
  - [6:0]=fill level, [8]=empty, [9]=full, [10]=overrun (sticky).
  - Writing 1 to bit 10 clears overrun.
- CONTROL (addr 2):
  - [0]=enable, [1]=irq_mask.
  - [2]=flush: write-only, self-clearing, always reads 0.
- TIMEOUT (addr 3):
  - [CNT_WIDTH-1:0] read/write.
  - Value 0 disables the timeout.
- FSM (priority order):
  - enable=0 from any state -> IDLE next cycle; cnt=0; FIFO contents kept.
  - IDLE: edges ignored; enable=1 -> WAIT_EDGE.
  - WAIT_EDGE: edge -> MEASURE with cnt<=1; nothing pushed.
  - MEASURE, edge:
    - push {lvl_d, 0, cnt}; cnt<=1; stay in MEASURE.
    - Duration = cycles between consecutive edges.
  - MEASURE, no edge, TIMEOUT!=0 and cnt==TIMEOUT:
    - push {lvl, 1, cnt}; -> WAIT_EDGE.
  - MEASURE, otherwise:
    - cnt<=cnt+1, saturating at all-ones.
    - With TIMEOUT=0, nothing is pushed on saturation.
- FIFO rules:
  - Push when full with no pop in the same cycle: entry dropped, overrun<=1.
  - Push and pop in the same cycle: both occur, including when full; level unchanged.
  - Flush write: FIFO empties at that edge; a push or pop in the same cycle is discarded. Overrun is not cleared.
- irq = irq_mask & (~empty | overrun). It is a direct function of registers, so no extra latency.

Optional Feature:
- Macro: IR_GLITCH_FILTER_EN.
- Defined:
  - A filtered level replaces lvl.
  - Filtered level flips only after s2 differs from it for GLITCH_CYCLES consecutive cycles.
  - Pulses shorter than GLITCH_CYCLES are invisible.
  - Edges are delayed by GLITCH_CYCLES; measured durations of valid pulses are unchanged.
- Undefined:
  - No filter counter exists; lvl=s2 directly.

Test Plan:
- Reset, write CONTROL=3, TIMEOUT=1000:
  - Drive ir_in 1->0, hold low 560 cycles, then high.
  - DATA reads 0x00000230 (level 0, dur 560); irq=1 until popped, then 0.
- After a last edge, hold ir_in stable with TIMEOUT=1000:
  - Exactly one entry 0x40000000|1000 (with level bit) is pushed; FSM stays in WAIT_EDGE; further idle pushes nothing.
- With FIFO_DEPTH=16, generate 17 pulses without reading:
  - STATUS shows full=1, level=16, overrun=1; first 16 durations read back in order.
  - Write STATUS bit 10 -> overrun=0.
- Fill FIFO to full, then issue a DATA read in the same cycle as a new edge:
  - Level stays 16; overrun stays 0; new entry is last out.
- Mid-MEASURE, clear enable, then re-enable and toggle ir_in:
  - No push on the disable edge; the first post-enable edge pushes nothing; the next edge pushes a correct duration.
- IR_GLITCH_FILTER_EN, GLITCH_CYCLES=8:
  - A 5-cycle low glitch produces no entry.
  - A 100-cycle low pulse produces an entry with duration 100.
